cmd_arb: RTL and testbench

CMD_ARB -- requirements
Module: cmd_arb

---
 rtl/knight_pkg.sv | 34 +++
 rtl/cmd_arb_if.sv | 38 +++
 rtl/exec_wdog.sv | 33 +++
 rtl/cmd_arb.sv | 135 +++++++++++++
 tb/tb_cmd_arb.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/knight_pkg.sv
// knight_pkg: definitions shared by the command arbiter and its neighbours.
//   opc_e       - command opcode nibble, cmd[15:12]
//   FanfareBit  - bit position of the fanfare flag inside a command word
//   resp_e      - response bytes returned to the remote link
//   arb_state_e - command arbiter FSM states
package knight_pkg;

  typedef enum logic [3:0] {
    OpcCal  = 4'h0,
    OpcMov  = 4'h2,
    OpcTour = 4'h4
  } opc_e;

  localparam int unsigned FanfareBit = 12;

  typedef enum logic [7:0] {
    RespOk   = 8'hA5,  // command complete / tour finished
    RespMove = 8'h5A,  // one tour move complete, tour continues
    RespTmo  = 8'hEE   // processor never reported done
  } resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StRIssue,
    StRExec,
    StTIssue,
    StTExec
  } arb_state_e;

  function automatic logic is_tour(input logic [15:0] cmd);
    return cmd[15:12] == OpcTour;
  endfunction

endpackage

// File: rtl/cmd_arb_if.sv
// cmd_arb_if: handshake bundle between the command sources (remote link, tour
// logic), the command arbiter and the command processor.
//   rmt_cmd/rmt_vld/rmt_clr     - remote command, valid held until clr pulse
//   tour_cmd/tour_vld/tour_clr  - tour move command, valid held until clr pulse
//   tour_fin/tour_go/tour_mode  - tour finished / tour start / tour owns processor
//   proc_cmd/proc_rdy/proc_clr  - command to processor, rdy held until clr pulse
//   proc_done                   - processor finished current command
//   resp/resp_vld               - response byte to remote, valid for one clock
// modport slave is the arbiter; modport master is its environment.
interface cmd_arb_if;

  logic [15:0] rmt_cmd;
  logic        rmt_vld;
  logic        rmt_clr;
  logic [15:0] tour_cmd;
  logic        tour_vld;
  logic        tour_clr;
  logic        tour_fin;
  logic        tour_go;
  logic        tour_mode;
  logic [15:0] proc_cmd;
  logic        proc_rdy;
  logic        proc_clr;
  logic        proc_done;
  logic [7:0]  resp;
  logic        resp_vld;

  modport slave (
    input  rmt_cmd, rmt_vld, tour_cmd, tour_vld, tour_fin, proc_clr, proc_done,
    output rmt_clr, tour_clr, tour_go, tour_mode, proc_cmd, proc_rdy, resp, resp_vld
  );

  modport master (
    output rmt_cmd, rmt_vld, tour_cmd, tour_vld, tour_fin, proc_clr, proc_done,
    input  rmt_clr, tour_clr, tour_go, tour_mode, proc_cmd, proc_rdy, resp, resp_vld
  );

endinterface

// File: rtl/exec_wdog.sv
// exec_wdog: execution watchdog counter.
//   clk, rst_n  - clock, synchronous active-low reset
//   i_clr       - clear count to zero
//   i_en        - count one clock
//   o_expired   - high when the next counted clock reaches EXEC_TMO
module exec_wdog #(
  parameter int unsigned EXEC_TMO = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = $clog2(EXEC_TMO + 1);

  logic [W-1:0] r_cnt;

  // Flag one count early so the owner acts on the edge where the count hits EXEC_TMO.
  assign o_expired = (r_cnt == W'(EXEC_TMO - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_arb.sv
// cmd_arb: arbitrates remote and tour commands onto the command processor.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - cmd_arb_if.slave: remote/tour command handshakes, processor
//                handshake, tour control and response byte
// A remote TOUR opcode hands the processor to the tour logic until the tour
// reports it is finished; remote commands wait (uncleared) meanwhile.
module cmd_arb
  import knight_pkg::*;
#(
  parameter int unsigned EXEC_TMO = 2_500_000
) (
  input logic      clk,
  input logic      rst_n,
  cmd_arb_if.slave bus
);

  arb_state_e  r_state;
  logic [15:0] r_proc_cmd;
  logic        r_proc_rdy;
  logic        r_rmt_clr;
  logic        r_tour_clr;
  logic        r_tour_go;
  logic        r_tour_mode;
  logic        r_fin_pend;
  logic [7:0]  r_resp;
  logic        r_resp_vld;

  logic w_idle;
  logic w_issue;
  logic w_tour_side;
  logic w_complete;
  logic w_expired;

  assign w_idle      = (r_state == StIdle);
  assign w_issue     = (r_state == StRIssue) || (r_state == StTIssue);
  assign w_tour_side = (r_state == StTIssue) || (r_state == StTExec);
  // A done racing the clr in an ISSUE state still completes the command.
  assign w_complete  = bus.proc_done && (!w_issue || bus.proc_clr);

  // Held clear while idle, so every ISSUE entry starts from zero.
  exec_wdog #(
    .EXEC_TMO(EXEC_TMO)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_idle),
    .i_en     (!w_idle),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_proc_cmd  <= '0;
      r_proc_rdy  <= 1'b0;
      r_rmt_clr   <= 1'b0;
      r_tour_clr  <= 1'b0;
      r_tour_go   <= 1'b0;
      r_tour_mode <= 1'b0;
      r_fin_pend  <= 1'b0;
      r_resp      <= '0;
      r_resp_vld  <= 1'b0;
    end else begin
      r_rmt_clr  <= 1'b0;
      r_tour_clr <= 1'b0;
      r_tour_go  <= 1'b0;
      r_resp_vld <= 1'b0;
      case (r_state)
        StIdle: begin
          if (!r_tour_mode) begin
            if (bus.rmt_vld) begin
              r_rmt_clr <= 1'b1;
              if (is_tour(bus.rmt_cmd)) begin
                r_tour_go   <= 1'b1;
                r_tour_mode <= 1'b1;
              end else begin
                r_proc_cmd <= bus.rmt_cmd;
                r_proc_rdy <= 1'b1;
                r_state    <= StRIssue;
              end
            end
          end else if (bus.tour_fin) begin
            // Tour ended between moves.
            r_resp      <= RespOk;
            r_resp_vld  <= 1'b1;
            r_tour_mode <= 1'b0;
          end else if (bus.tour_vld) begin
            r_proc_cmd <= bus.tour_cmd;
            r_proc_rdy <= 1'b1;
            r_tour_clr <= 1'b1;
            r_state    <= StTIssue;
          end
        end
        StRIssue, StRExec, StTIssue, StTExec: begin
          if (w_tour_side && bus.tour_fin) r_fin_pend <= 1'b1;
          if (w_complete) begin
            r_proc_rdy <= 1'b0;
            r_resp_vld <= 1'b1;
            r_resp     <= RespOk;
            r_state    <= StIdle;
            if (w_tour_side) begin
              if (bus.tour_fin || r_fin_pend) begin
                r_tour_mode <= 1'b0;
                r_fin_pend  <= 1'b0;
              end else begin
                r_resp <= RespMove;
              end
            end
          end else if (w_expired) begin
            r_proc_rdy  <= 1'b0;
            r_resp      <= RespTmo;
            r_resp_vld  <= 1'b1;
            r_tour_mode <= 1'b0;
            r_fin_pend  <= 1'b0;
            r_state     <= StIdle;
          end else if (w_issue && bus.proc_clr) begin
            r_proc_rdy <= 1'b0;
            r_state    <= w_tour_side ? StTExec : StRExec;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rmt_clr   = r_rmt_clr;
  assign bus.tour_clr  = r_tour_clr;
  assign bus.tour_go   = r_tour_go;
  assign bus.tour_mode = r_tour_mode;
  assign bus.proc_cmd  = r_proc_cmd;
  assign bus.proc_rdy  = r_proc_rdy;
  assign bus.resp      = r_resp;
  assign bus.resp_vld  = r_resp_vld;

endmodule

// File: tb/tb_cmd_arb.sv
// tb_cmd_arb: table-driven vectors, directed multi-cycle sequences and a
// randomized scenario scoreboard for cmd_arb.
module tb_cmd_arb;

  localparam int unsigned Tmo = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_arb_if u_if ();

  cmd_arb #(
    .EXEC_TMO(Tmo)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  typedef struct packed {
    logic        rst_n;
    logic        rv;
    logic [15:0] rc;
    logic        tv;
    logic [15:0] tc;
    logic        tf;
    logic        pc;
    logic        pd;
    logic [29:0] ex;
  } vec_t;

  vec_t        vecs[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_rmt_clr = 0;
  logic [7:0]  got_resp[$];
  logic [7:0]  exp_resp[$];
  logic [15:0] got_cmd[$];
  logic [15:0] exp_cmd[$];
  logic        prev_rdy = 1'b0;
  logic [3:0]  prev_p = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] e(input int rclr, input int tclr, input int go, input int tm,
                                    input int rdy, input logic [15:0] cmd, input int rv,
                                    input logic [7:0] rs);
    return {rclr[0], tclr[0], go[0], tm[0], rdy[0], cmd, rv[0], rs};
  endfunction

  function automatic void add(input int r, input int rv, input logic [15:0] rc, input int tv,
                              input logic [15:0] tc, input int tf, input int pc, input int pd,
                              input logic [29:0] ex);
    vec_t x;
    x.rst_n = r[0]; x.rv = rv[0]; x.rc = rc; x.tv = tv[0]; x.tc = tc;
    x.tf = tf[0]; x.pc = pc[0]; x.pd = pd[0]; x.ex = ex;
    vecs.push_back(x);
  endfunction

  function automatic logic [29:0] outs();
    return {u_if.rmt_clr, u_if.tour_clr, u_if.tour_go, u_if.tour_mode, u_if.proc_rdy,
            u_if.proc_cmd, u_if.resp_vld, u_if.resp};
  endfunction

  task automatic idle_inputs();
    u_if.rmt_vld = 1'b0; u_if.rmt_cmd = 16'h0; u_if.tour_vld = 1'b0; u_if.tour_cmd = 16'h0;
    u_if.tour_fin = 1'b0; u_if.proc_clr = 1'b0; u_if.proc_done = 1'b0;
  endtask

  // One clock; sample 1 time unit after the edge and feed the scoreboard.
  task automatic step();
    logic [3:0] p;
    @(posedge clk);
    #1;
    p = {u_if.resp_vld, u_if.tour_go, u_if.tour_clr, u_if.rmt_clr};
    if (|p) chk("pulse_one_clock", {28'd0, p & prev_p}, 32'd0);
    prev_p = p;
    if (u_if.rmt_clr) n_rmt_clr++;
    if (u_if.resp_vld) got_resp.push_back(u_if.resp);
    if (u_if.proc_rdy && !prev_rdy) got_cmd.push_back(u_if.proc_cmd);
    prev_rdy = u_if.proc_rdy;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_clr(input bit tour, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = tour ? u_if.tour_clr : u_if.rmt_clr;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic rmt_send(input logic [15:0] c);
    u_if.rmt_vld = 1'b1;
    u_if.rmt_cmd = c;
    wait_clr(1'b0, "rmt_accept");
    u_if.rmt_vld = 1'b0;
  endtask

  // Processor side: d1 clocks, then clr (with done if d2==0), else done d2 clocks later.
  // tour_fin is pulsed on step fin_at (-1: never).
  task automatic proc_xact(input int d1, input int d2, input int fin_at);
    int s = 0;
    for (int i = 0; i < d1; i++) begin
      u_if.tour_fin = (s == fin_at); step(); s++;
    end
    u_if.proc_clr = 1'b1; u_if.proc_done = (d2 == 0); u_if.tour_fin = (s == fin_at);
    step(); s++;
    u_if.proc_clr = 1'b0; u_if.proc_done = 1'b0;
    if (d2 != 0) begin
      for (int i = 1; i < d2; i++) begin
        u_if.tour_fin = (s == fin_at); step(); s++;
      end
      u_if.proc_done = 1'b1; u_if.tour_fin = (s == fin_at); step();
      u_if.proc_done = 1'b0;
    end
    u_if.tour_fin = 1'b0;
  endtask

  task automatic tour_move(input logic [15:0] c, input int d1, input int d2, input int fin_at);
    u_if.tour_vld = 1'b1;
    u_if.tour_cmd = c;
    wait_clr(1'b1, "tour_accept");
    u_if.tour_vld = 1'b0;
    chk("tour_proc_cmd", {16'd0, u_if.proc_cmd}, {16'd0, c});
    proc_xact(d1, d2, fin_at);
  endtask

  task automatic tmo_seq(input bit tour);
    int first = -1;
    if (tour) begin
      rmt_send(16'h4000);
      u_if.tour_vld = 1'b1; u_if.tour_cmd = 16'h2BF0;
      wait_clr(1'b1, "tmo_tour_accept");
      u_if.tour_vld = 1'b0;
    end else begin
      rmt_send(16'h2000);
    end
    for (int k = 1; k <= int'(Tmo) + 4; k++) begin
      u_if.proc_clr = (tour && k == 1);
      step();
      u_if.proc_clr = 1'b0;
      if (u_if.resp_vld && first < 0) first = k;
      if (k == int'(Tmo) - 1) chk("tmo_rdy_before", {31'd0, u_if.proc_rdy}, {31'd0, !tour});
      if (k == int'(Tmo)) begin
        chk("tmo_resp", {24'd0, u_if.resp}, 32'h0000_00EE);
        chk("tmo_rdy", {31'd0, u_if.proc_rdy}, 32'd0);
        chk("tmo_tour_mode", {31'd0, u_if.tour_mode}, 32'd0);
      end
    end
    chk("tmo_cycle", first, Tmo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] c;
    int n, k, d1, d2, fin_at;

    // rst rv rc tv tc tf pc pd | rclr tclr go tm rdy cmd rvld resp
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, e(0, 0, 0, 0, 0, 16'h0000, 0, 8'h00));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, e(0, 0, 0, 0, 0, 16'h0000, 0, 8'h00));
    add(1, 0, 16'h0000, 1, 16'h2BF0, 0, 0, 0, e(0, 0, 0, 0, 0, 16'h0000, 0, 8'h00));
    add(1, 1, 16'h2000, 0, 16'h0000, 0, 0, 0, e(1, 0, 0, 0, 1, 16'h2000, 0, 8'h00));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, e(0, 0, 0, 0, 1, 16'h2000, 0, 8'h00));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, e(0, 0, 0, 0, 0, 16'h2000, 0, 8'h00));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, e(0, 0, 0, 0, 0, 16'h2000, 0, 8'h00));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, e(0, 0, 0, 0, 0, 16'h2000, 1, 8'hA5));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, e(0, 0, 0, 0, 0, 16'h2000, 0, 8'hA5));
    add(1, 1, 16'h0123, 0, 16'h0000, 0, 0, 0, e(1, 0, 0, 0, 1, 16'h0123, 0, 8'hA5));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, e(0, 0, 0, 0, 0, 16'h0123, 1, 8'hA5));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, e(0, 0, 0, 0, 0, 16'h0123, 0, 8'hA5));
    add(1, 1, 16'h4000, 0, 16'h0000, 0, 0, 0, e(1, 0, 1, 1, 0, 16'h0123, 0, 8'hA5));
    add(1, 1, 16'h1000, 0, 16'h0000, 0, 0, 0, e(0, 0, 0, 1, 0, 16'h0123, 0, 8'hA5));
    add(1, 1, 16'h1000, 0, 16'h0000, 1, 0, 0, e(0, 0, 0, 0, 0, 16'h0123, 1, 8'hA5));
    add(1, 1, 16'h1000, 0, 16'h0000, 0, 0, 0, e(1, 0, 0, 0, 1, 16'h1000, 0, 8'hA5));
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, e(0, 0, 0, 0, 0, 16'h0000, 0, 8'h00));
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, e(0, 0, 0, 0, 0, 16'h0000, 0, 8'h00));

    idle_inputs();
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      u_if.rmt_vld = vecs[i].rv; u_if.rmt_cmd = vecs[i].rc;
      u_if.tour_vld = vecs[i].tv; u_if.tour_cmd = vecs[i].tc;
      u_if.tour_fin = vecs[i].tf; u_if.proc_clr = vecs[i].pc; u_if.proc_done = vecs[i].pd;
      step();
      chk($sformatf("vec%0d", i), {2'b00, outs()}, {2'b00, vecs[i].ex});
    end
    idle_inputs();
    rst_n = 1'b1;
    step();

    // Tour of three moves with a remote command held throughout.
    rmt_send(16'h4000);
    chk("tour_go", {31'd0, u_if.tour_go}, 32'd1);
    chk("tour_mode_set", {31'd0, u_if.tour_mode}, 32'd1);
    u_if.rmt_vld = 1'b1; u_if.rmt_cmd = 16'h1000;
    n_rmt_clr = 0;
    tour_move(16'h2BF0, 1, 1, -1);
    chk("move1_resp", {23'd0, u_if.resp_vld, u_if.resp}, {23'd0, 1'b1, 8'h5A});
    tour_move(16'h27F0, 0, 2, -1);
    chk("move2_resp", {23'd0, u_if.resp_vld, u_if.resp}, {23'd0, 1'b1, 8'h5A});
    tour_move(16'h23F0, 1, 1, 1);
    chk("move3_resp", {23'd0, u_if.resp_vld, u_if.resp}, {23'd0, 1'b1, 8'hA5});
    chk("tour_mode_clr", {31'd0, u_if.tour_mode}, 32'd0);
    chk("rmt_held_in_tour", n_rmt_clr, 0);
    wait_clr(1'b0, "rmt_after_tour");
    u_if.rmt_vld = 1'b0;
    chk("rmt_after_tour_cmd", {16'd0, u_if.proc_cmd}, 32'h0000_1000);
    proc_xact(0, 0, -1);
    chk("rmt_after_tour_resp", {23'd0, u_if.resp_vld, u_if.resp}, {23'd0, 1'b1, 8'hA5});
    step();

    // Reset in the middle of an executing remote command.
    rmt_send(16'h2000);
    u_if.proc_clr = 1'b1; step(); u_if.proc_clr = 1'b0;
    rst_n = 1'b0; step();
    chk("reset_mid_exec", {2'b00, outs()}, 32'd0);
    rst_n = 1'b1; u_if.proc_done = 1'b1; step(); u_if.proc_done = 1'b0;
    chk("stale_done", {2'b00, outs()}, 32'd0);
    step();
    chk("idle_after_reset", {2'b00, outs()}, 32'd0);

    tmo_seq(1'b0);
    tmo_seq(1'b1);
    gap(2);

    // Randomized scenarios against a transaction-level expectation.
    got_resp.delete(); exp_resp.delete(); got_cmd.delete(); exp_cmd.delete();
    for (int s = 0; s < 40; s++) begin
      gap($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h4) op = 4'h2;
        c = {op, 12'($urandom)};
        exp_cmd.push_back(c);
        exp_resp.push_back(8'hA5);
        rmt_send(c);
        proc_xact($urandom_range(0, 3), $urandom_range(0, 3), -1);
      end else begin
        n = $urandom_range(1, 4);
        k = $urandom_range(0, n);  // move index carrying tour_fin; n = after last move
        rmt_send({4'h4, 12'($urandom)});
        for (int j = 0; j < n && j <= k; j++) begin
          c = {4'h2, 12'($urandom)};
          exp_cmd.push_back(c);
          exp_resp.push_back((j == k) ? 8'hA5 : 8'h5A);
          d1 = $urandom_range(0, 3);
          d2 = $urandom_range(0, 3);
          fin_at = (j == k) ? $urandom_range(0, d1 + d2) : -1;
          gap($urandom_range(0, 1));
          tour_move(c, d1, d2, fin_at);
        end
        if (k == n) begin
          exp_resp.push_back(8'hA5);
          gap($urandom_range(1, 2));
          u_if.tour_fin = 1'b1; step(); u_if.tour_fin = 1'b0;
        end
      end
      chk("scenario_tour_mode", {31'd0, u_if.tour_mode}, 32'd0);
    end
    step();
    chk("rand_resp_count", got_resp.size(), exp_resp.size());
    for (int i = 0; i < exp_resp.size() && i < got_resp.size(); i++)
      chk($sformatf("rand_resp%0d", i), {24'd0, got_resp[i]}, {24'd0, exp_resp[i]});
    chk("rand_cmd_count", got_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
      chk($sformatf("rand_cmd%0d", i), {16'd0, got_cmd[i]}, {16'd0, exp_cmd[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
